// File: rtl/bg_mean_estimator_pkg.sv
// Shared constants, state encoding and flag decode for the background-mean estimator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bg_mean_estimator_pkg;

    localparam int CH_W           = 8;
    localparam int NUM_PIXELS_DEF = 25;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DIV   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One-hot flag vector in port order {Qi, Qa, Qv, Qd}
    function automatic logic [3:0] state_flags(input state_t s);
        logic [3:0] f;
        f = 4'b1000;
        case (s)
            ST_INIT:  f = 4'b1000;
            ST_ACCUM: f = 4'b0100;
            ST_DIV:   f = 4'b0010;
            ST_DONE:  f = 4'b0001;
            default:  f = 4'b1000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bg_div_serial.sv
// Restoring serial divider, one quotient bit per cycle MSB first; keeps the low CH_W quotient bits.
// Latency: first bit computed on the load edge, quotient valid ACC_W-1 cycles later (busy low).
// Backpressure: none; load must only be pulsed while busy is low.
module bg_div_serial
    import bg_mean_estimator_pkg::*;
#(
    parameter int ACC_W = 13,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [ACC_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [CH_W-1:0]  quotient,
    output logic             busy
);

    localparam int STEP_W = $clog2(ACC_W + 1);

    logic [CNT_W-1:0]  rem;
    logic [ACC_W-1:0]  dvd;
    logic [CNT_W-1:0]  dvs;
    logic [CH_W-1:0]   quo;
    logic [STEP_W-1:0] left;

    logic [CNT_W-1:0]  src_rem;
    logic              src_bit;
    logic [CNT_W-1:0]  src_div;
    logic [CNT_W:0]    trial;
    logic [CNT_W-1:0]  rem_nxt;
    logic              q_bit;

    // One restoring step; on the load cycle it works straight from the new operands
    always_comb begin
        src_rem = load ? '0 : rem;
        src_bit = load ? dividend[ACC_W-1] : dvd[ACC_W-1];
        src_div = load ? divisor : dvs;
        trial   = {src_rem, src_bit};
        q_bit   = 1'b0;
        rem_nxt = trial[CNT_W-1:0];
        if (trial >= {1'b0, src_div}) begin
            q_bit   = 1'b1;
            // remainder is always below the divisor, so it fits in CNT_W bits
            rem_nxt = CNT_W'(trial - {1'b0, src_div});
        end
    end

    // Iteration state: shift dividend out, shift quotient bits in
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rem  <= '0;
            dvd  <= '0;
            dvs  <= '0;
            quo  <= '0;
            left <= '0;
            busy <= 1'b0;
        end else if (load) begin
            rem  <= rem_nxt;
            dvd  <= {dividend[ACC_W-2:0], 1'b0};
            dvs  <= divisor;
            quo  <= {{(CH_W-1){1'b0}}, q_bit};
            left <= STEP_W'(ACC_W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= rem_nxt;
            dvd  <= {dvd[ACC_W-2:0], 1'b0};
            quo  <= {quo[CH_W-2:0], q_bit};
            left <= left - STEP_W'(1);
            if (left == STEP_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/bg_mean_estimator.sv
// Frame RGB mean estimator: accumulate up to NUM_PIXELS samples, divide each sum by the count.
// Latency: last accepted sample to Qd high is ACC_W+1 cycles. Optional BG_MEAN_ROUND_EN = round-half-up.
// Backpressure: pix_ready high only while accumulating; Start/Ack handshake frames the result.
module bg_mean_estimator
    import bg_mean_estimator_pkg::*;
#(
    parameter  int NUM_PIXELS = NUM_PIXELS_DEF,
    localparam int CNT_W      = $clog2(NUM_PIXELS + 1),
    localparam int ACC_W      = CH_W + CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             pix_valid,
    input  logic             pix_last,
    input  logic [CH_W-1:0]  red_in,
    input  logic [CH_W-1:0]  green_in,
    input  logic [CH_W-1:0]  blue_in,
    output logic             pix_ready,
    output logic [CH_W-1:0]  red_exp,
    output logic [CH_W-1:0]  green_exp,
    output logic [CH_W-1:0]  blue_exp,
    output logic [CNT_W-1:0] pix_count,
    output logic             Qi,
    output logic             Qa,
    output logic             Qv,
    output logic             Qd
);

    state_t            state;
    logic [ACC_W-1:0]  acc_r, acc_g, acc_b;
    logic [ACC_W-1:0]  acc_r_nxt, acc_g_nxt, acc_b_nxt;
    logic [ACC_W-1:0]  dvd_r, dvd_g, dvd_b;
    logic [CNT_W-1:0]  count_inc;
    logic              accept;
    logic              close;
    logic [CH_W-1:0]   q_r, q_g, q_b;
    logic              busy_r, busy_g, busy_b;
    logic              div_busy;

    assign accept    = (state == ST_ACCUM) && pix_valid;
    assign count_inc = pix_count + CNT_W'(1);
    assign close     = accept && (pix_last || (count_inc == CNT_W'(NUM_PIXELS)));

    assign acc_r_nxt = acc_r + ACC_W'(red_in);
    assign acc_g_nxt = acc_g + ACC_W'(green_in);
    assign acc_b_nxt = acc_b + ACC_W'(blue_in);

    // Dividers load on the closing accept, so the final sample is folded in combinationally
`ifdef BG_MEAN_ROUND_EN
    logic [ACC_W-1:0] half_cnt;
    assign half_cnt = ACC_W'(count_inc >> 1);
    assign dvd_r    = acc_r_nxt + half_cnt;
    assign dvd_g    = acc_g_nxt + half_cnt;
    assign dvd_b    = acc_b_nxt + half_cnt;
`else
    assign dvd_r    = acc_r_nxt;
    assign dvd_g    = acc_g_nxt;
    assign dvd_b    = acc_b_nxt;
`endif

    bg_div_serial #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_div_r (
        .Clk(Clk), .Reset(Reset), .load(close), .dividend(dvd_r),
        .divisor(count_inc), .quotient(q_r), .busy(busy_r)
    );
    bg_div_serial #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_div_g (
        .Clk(Clk), .Reset(Reset), .load(close), .dividend(dvd_g),
        .divisor(count_inc), .quotient(q_g), .busy(busy_g)
    );
    bg_div_serial #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_div_b (
        .Clk(Clk), .Reset(Reset), .load(close), .dividend(dvd_b),
        .divisor(count_inc), .quotient(q_b), .busy(busy_b)
    );

    assign div_busy = busy_r | busy_g | busy_b;

    // Frame FSM with registered flags, ready, counter, accumulators and results
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state             <= ST_INIT;
            {Qi, Qa, Qv, Qd}  <= state_flags(ST_INIT);
            pix_ready         <= 1'b0;
            pix_count         <= '0;
            acc_r             <= '0;
            acc_g             <= '0;
            acc_b             <= '0;
            red_exp           <= '0;
            green_exp         <= '0;
            blue_exp          <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (Start) begin
                        acc_r            <= '0;
                        acc_g            <= '0;
                        acc_b            <= '0;
                        pix_count        <= '0;
                        state            <= ST_ACCUM;
                        {Qi, Qa, Qv, Qd} <= state_flags(ST_ACCUM);
                        pix_ready        <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_r     <= acc_r_nxt;
                        acc_g     <= acc_g_nxt;
                        acc_b     <= acc_b_nxt;
                        pix_count <= count_inc;
                        if (close) begin
                            state            <= ST_DIV;
                            {Qi, Qa, Qv, Qd} <= state_flags(ST_DIV);
                            pix_ready        <= 1'b0;
                        end
                    end
                end
                ST_DIV: begin
                    // dividers finish one cycle before this edge; exactly ACC_W cycles in DIV
                    if (!div_busy) begin
                        red_exp          <= q_r;
                        green_exp        <= q_g;
                        blue_exp         <= q_b;
                        state            <= ST_DONE;
                        {Qi, Qa, Qv, Qd} <= state_flags(ST_DONE);
                    end
                end
                ST_DONE: begin
                    if (Ack) begin
                        state            <= ST_INIT;
                        {Qi, Qa, Qv, Qd} <= state_flags(ST_INIT);
                    end
                end
                default: begin
                    state            <= ST_INIT;
                    {Qi, Qa, Qv, Qd} <= state_flags(ST_INIT);
                    pix_ready        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bg_mean_estimator.sv
// Directed self-checking bench for bg_mean_estimator.
// Latency: checks the ACC_W+1 cycle accept-to-Qd timing.
// Backpressure: exercises pix_valid gaps, ignored inputs and the Ack hold.
module tb_bg_mean_estimator;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       pix_valid;
    logic       pix_last;
    logic [7:0] red_in, green_in, blue_in;
    logic       pix_ready;
    logic [7:0] red_exp, green_exp, blue_exp;
    logic [4:0] pix_count;
    logic       Qi, Qa, Qv, Qd;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BG_MEAN_ROUND_EN
    localparam logic [7:0] EXP_T2   = 8'd128;
    localparam logic [7:0] EXP_T3_R = 8'd21;
`else
    localparam logic [7:0] EXP_T2   = 8'd127;
    localparam logic [7:0] EXP_T3_R = 8'd20;
`endif

    bg_mean_estimator dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .pix_valid(pix_valid), .pix_last(pix_last),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pix_ready(pix_ready),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
        .pix_count(pix_count),
        .Qi(Qi), .Qa(Qa), .Qv(Qv), .Qd(Qd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic last);
        pix_valid = 1'b1;
        red_in    = r;
        green_in  = g;
        blue_in   = b;
        pix_last  = last;
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic start_frame();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic ack_done();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Ack = 1'b0;
        pix_valid = 1'b0; pix_last = 1'b0;
        red_in = '0; green_in = '0; blue_in = '0;
        ticks(2);
        Reset = 1'b0;

        // reset state
        chk("rst_flags", {Qi, Qa, Qv, Qd}, 4'b1000);
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_count", pix_count, 5'd0);
        chk("rst_exp", {red_exp, green_exp, blue_exp}, 24'd0);

        // pix_valid in INIT is ignored
        send(8'd9, 8'd9, 8'd9, 1'b1);
        chk("init_ignore_valid", {Qi, pix_count}, {1'b1, 5'd0});

        // test 1: 25 samples, auto-close, 14-cycle latency
        start_frame();
        chk("t1_accum_flags", {Qi, Qa, Qv, Qd, pix_ready}, 5'b01001);
        for (int i = 0; i < 25; i++) send(8'd61, 8'd133, 8'd198, 1'b0);
        chk("t1_div_entry", {Qi, Qa, Qv, Qd, pix_ready}, 5'b00100);
        ticks(12);
        chk("t1_still_div_13", {Qv, Qd}, 2'b10);
        tick();
        chk("t1_done_14", {Qi, Qa, Qv, Qd}, 4'b0001);
        chk("t1_exp", {red_exp, green_exp, blue_exp}, {8'd61, 8'd133, 8'd198});
        chk("t1_count", pix_count, 5'd25);
        ack_done();
        chk("t1_ack_init", {Qi, Qd}, 2'b10);
        chk("t1_init_hold_exp", red_exp, 8'd61);

        // test 2: two samples, early close
        start_frame();
        send(8'd0, 8'd0, 8'd0, 1'b0);
        send(8'd255, 8'd255, 8'd255, 1'b1);
        chk("t2_div", Qv, 1'b1);
        ticks(13);
        chk("t2_done", Qd, 1'b1);
        chk("t2_exp", {red_exp, green_exp, blue_exp}, {EXP_T2, EXP_T2, EXP_T2});
        chk("t2_count", pix_count, 5'd2);
        ack_done();

        // test 3: three samples, Start held during ACCUM is ignored
        start_frame();
        Start = 1'b1;
        send(8'd10, 8'd0, 8'd100, 1'b0);
        send(8'd20, 8'd0, 8'd100, 1'b0);
        chk("t3_start_ignored", {Qa, pix_count}, {1'b1, 5'd2});
        send(8'd32, 8'd0, 8'd101, 1'b1);
        Start = 1'b0;
        ticks(13);
        chk("t3_done", Qd, 1'b1);
        chk("t3_exp", {red_exp, green_exp, blue_exp}, {EXP_T3_R, 8'd0, 8'd100});
        chk("t3_count", pix_count, 5'd3);

        // test 5: hold in DONE with Ack low, junk on other inputs
        Start     = 1'b1;
        pix_valid = 1'b1;
        red_in    = 8'd1;
        ticks(10);
        chk("t5_hold_flags", {Qi, Qa, Qv, Qd, pix_ready}, 5'b00010);
        chk("t5_hold_exp", {red_exp, green_exp, blue_exp}, {EXP_T3_R, 8'd0, 8'd100});
        chk("t5_hold_count", pix_count, 5'd3);
        Start     = 1'b0;
        pix_valid = 1'b0;
        ack_done();
        chk("t5_ack_init", {Qi, Qa, Qv, Qd}, 4'b1000);

        // test 6: 1-on/2-off gaps over 25 samples of 200
        start_frame();
        for (int i = 0; i < 25; i++) begin
            ticks(2);
            if (i == 5) chk("t6_gap_count", pix_count, 5'd5);
            send(8'd200, 8'd200, 8'd200, 1'b0);
        end
        chk("t6_div", Qv, 1'b1);
        ticks(13);
        chk("t6_done", Qd, 1'b1);
        chk("t6_exp", {red_exp, green_exp, blue_exp}, {8'd200, 8'd200, 8'd200});
        chk("t6_count", pix_count, 5'd25);
        ack_done();

        // test 4: reset two cycles into DIV
        start_frame();
        for (int i = 0; i < 3; i++) send(8'd255, 8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 8'd255, 1'b1);
        ticks(2);
        chk("t4_in_div", Qv, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t4_rst_flags", {Qi, Qa, Qv, Qd, pix_ready}, 5'b10000);
        chk("t4_rst_exp", {red_exp, green_exp, blue_exp}, 24'd0);
        chk("t4_rst_count", pix_count, 5'd0);
        ticks(14);
        chk("t4_stays_init", {Qi, Qd}, 2'b10);

        // single-sample frame after reset
        start_frame();
        send(8'd7, 8'd8, 8'd9, 1'b1);
        ticks(13);
        chk("t7_done", Qd, 1'b1);
        chk("t7_exp", {red_exp, green_exp, blue_exp}, {8'd7, 8'd8, 8'd9});
        chk("t7_count", pix_count, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
